// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle Moore sequencer for the lab datapath: accepts one register-level
// operation per start/done handshake and drives every datapath control input.
module datapath_seq_ctrl #(
    parameter int RN_W = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [RN_W-1:0] rd,
    input  logic [RN_W-1:0] rn,
    input  logic [RN_W-1:0] rm,
    input  logic [1:0]      sh,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [RN_W-1:0] readnum,
    output logic [RN_W-1:0] writenum,
    output logic            write,
    output logic            vsel,
    output logic            loada,
    output logic            loadb,
    output logic            asel,
    output logic            bsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic            loadc,
    output logic            loads
);

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    typedef enum logic [2:0] {
        S_WAIT,
        S_LDA,
        S_LDB,
        S_EXEC,
        S_WB,
        S_DONE
    } state_e;

    state_e            state, state_next;
    logic [2:0]        op_q;
    logic [RN_W-1:0]   rd_q, rn_q, rm_q;
    logic [1:0]        sh_q;
    logic              op_illegal;

    assign op_illegal = (op_q[2:1] == 2'b11);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_WAIT;
            op_q  <= '0;
            rd_q  <= '0;
            rn_q  <= '0;
            rm_q  <= '0;
            sh_q  <= '0;
        end else begin
            state <= state_next;
            // Fields are captured only on accept, so the source may move on afterwards.
            if (state == S_WAIT && start) begin
                op_q <= op;
                rd_q <= rd;
                rn_q <= rn;
                rm_q <= rm;
                sh_q <= sh;
            end
        end
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        readnum    = '0;
        writenum   = '0;
        write      = 1'b0;
        vsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        loadc      = 1'b0;
        loads      = 1'b0;

        unique case (state)
            S_WAIT: begin
                busy = 1'b0;
                if (start) begin
                    unique case (op)
                        OP_MOVI:                 state_next = S_WB;
                        OP_MOV, OP_MVN:          state_next = S_LDB;
                        OP_ADD, OP_CMP, OP_AND:  state_next = S_LDA;
                        default:                 state_next = S_DONE;
                    endcase
                end
            end
            S_LDA: begin
                readnum    = rn_q;
                loada      = 1'b1;
                state_next = S_LDB;
            end
            S_LDB: begin
                readnum    = rm_q;
                loadb      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                shift = sh_q;
                unique case (op_q)
                    OP_CMP:  ALUop = 2'b01;
                    OP_AND:  ALUop = 2'b10;
                    OP_MVN:  ALUop = 2'b11;
                    default: ALUop = 2'b00;
                endcase
                // MOV and MVN pass only the shifted B operand through the ALU.
                asel       = (op_q == OP_MOV) || (op_q == OP_MVN);
                loadc      = (op_q != OP_CMP);
                loads      = (op_q == OP_ADD) || (op_q == OP_CMP) || (op_q == OP_AND);
                state_next = (op_q == OP_CMP) ? S_DONE : S_WB;
            end
            S_WB: begin
                writenum   = rd_q;
                write      = 1'b1;
                vsel       = (op_q == OP_MOVI);
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                err        = op_illegal;
                state_next = S_WAIT;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_WAIT;
            end
        endcase
    end

endmodule
